regfile_sb: RTL

Parametrised successor to the single-cycle register file, for the pipelined CPU. It adds configurable width and depth, write-to-read bypass and a per-register pending-write scoreboard. Decode issues destination registers into the scoreboard and writeback retires them. Hazard logic reads per-port busy flags instead of comparing pipeline addresses itself.

---
 rtl/cpu_regfile_pkg.sv | 15 +
 rtl/regfile_sb_cnt.sv | 32 +++
 rtl/regfile_sb.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_regfile_pkg.sv
// Shared definitions for the pipelined CPU register file.
// Holds default widths, derived register/counter limits and the
// hard-wired zero register index.
package cpu_regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned PEND_W_DEF = 2;

  localparam int unsigned NREGS    = 2 ** ADDR_W_DEF;
  localparam int unsigned PEND_MAX = (2 ** PEND_W_DEF) - 1;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_sb_cnt.sv
// Saturating up/down pending-write counter for one register.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   inc, dec   : count up (issue) / count down (retire); both = hold
//   cnt        : current count
//   zero, full : cnt == 0 / cnt == all ones
module regfile_sb_cnt #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              zero,
  output logic              full
);

  assign zero = (cnt == '0);
  assign full = (cnt == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + PEND_W'(1);
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - PEND_W'(1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass and a per-register
// pending-write scoreboard.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   RdReg1/RdReg2, RD1/RD2  : combinational read ports (r0 reads 0)
//   busy1/busy2             : read address has an uncommitted pending write
//   regWr/WrReg/WriteData   : writeback port (retires one pending write)
//   iss_en/iss_addr         : decode issues a destination register
//   iss_ready               : iss_addr counter not saturated
//   pend_any                : any pending write outstanding
//   err_wr                  : sticky, writeback to a register with no pending write
module regfile_sb
  import cpu_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PEND_W = PEND_W_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RdReg1,
  input  logic [ADDR_W-1:0] RdReg2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              busy1,
  output logic              busy2,
  input  logic              regWr,
  input  logic [ADDR_W-1:0] WrReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  output logic              pend_any,
  output logic              err_wr
);

  localparam int unsigned N_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [N_REGS];
  logic [PEND_W-1:0] cnt  [N_REGS];
  logic [N_REGS-1:0] zero_vec;
  logic [N_REGS-1:0] full_vec;

  logic wr_nz;
  logic iss_inc;
  logic wb_dec;

  assign wr_nz   = regWr && (WrReg != R0);
  assign iss_ready = (iss_addr == R0) || !full_vec[iss_addr];
  assign iss_inc = iss_en && iss_ready && (iss_addr != R0);
  assign wb_dec  = wr_nz && !zero_vec[WrReg];
  assign pend_any = ~&zero_vec;

  // r0 has no counter: permanently idle, never full.
  assign cnt[0]      = '0;
  assign zero_vec[0] = 1'b1;
  assign full_vec[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < N_REGS; r++) begin : g_cnt
      regfile_sb_cnt #(
        .PEND_W (PEND_W)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (iss_inc && (iss_addr == ADDR_W'(r))),
        .dec   (wb_dec && (WrReg == ADDR_W'(r))),
        .cnt   (cnt[r]),
        .zero  (zero_vec[r]),
        .full  (full_vec[r])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
      err_wr <= 1'b0;
    end else begin
      if (wr_nz) begin
        regs[WrReg] <= WriteData;
        if (zero_vec[WrReg]) begin
          err_wr <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (RdReg1 != R0) begin
      RD1 = (BYPASS != 0 && regWr && WrReg == RdReg1) ? WriteData : regs[RdReg1];
    end
    if (RdReg2 != R0) begin
      RD2 = (BYPASS != 0 && regWr && WrReg == RdReg2) ? WriteData : regs[RdReg2];
    end
  end

  // The final outstanding write is being forwarded this cycle, so the reader
  // already sees the committed value and need not stall.
  always_comb begin
    busy1 = !zero_vec[RdReg1];
    busy2 = !zero_vec[RdReg2];
    if (BYPASS != 0 && regWr && WrReg == RdReg1 && cnt[RdReg1] == PEND_W'(1)) begin
      busy1 = 1'b0;
    end
    if (BYPASS != 0 && regWr && WrReg == RdReg2 && cnt[RdReg2] == PEND_W'(1)) begin
      busy2 = 1'b0;
    end
  end

endmodule
